// File: rtl/seg_display_history.sv
// History-keeping, time-multiplexed 4-digit seven-segment output stage.
// Optional freeze input enabled with `define SEG_HISTORY_FREEZE_EN.
module seg_display_history #(
  parameter int REFRESH_DIV   = 100000,
  parameter int STABLE_CYCLES = 8,
  parameter int DIGITS        = 4
) (
  input  logic       boardCLK,
  input  logic       reset,
`ifdef SEG_HISTORY_FREEZE_EN
  input  logic       freeze,
`endif
  input  logic [3:0] cpuOut,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic [2:0] histCount
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [2:0]    FULL      = 3'(DIGITS);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [3:0]    cpu_s1_q, cpu_s2_q;
  logic [3:0]    cand_q, cand_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          commit;
  logic          frozen;
  logic [3:0]    hist_q [DIGITS];
  logic [2:0]    hcnt_q;
  logic [RW-1:0] ref_q;
  logic [1:0]    idx_q;
  logic          lit;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic          dp_q;

`ifdef SEG_HISTORY_FREEZE_EN
  logic frz_s1_q, frz_s2_q;
  assign frozen = frz_s2_q;
`else
  assign frozen = 1'b0;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    commit  = 1'b0;
    if (cpu_s2_q != cand_q) begin
      cand_d  = cpu_s2_q;
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q != STAB_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
    // A frozen terminal count stays armed so it can commit once freeze drops.
    if (armed_d && (cnt_d == STAB_LAST) && !frozen) begin
      armed_d = 1'b0;
      commit  = (hcnt_q == 3'd0) || (cand_d != hist_q[0]);
    end
  end

  assign lit = ({1'b0, idx_q} < hcnt_q);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      cpu_s1_q <= '0;
      cpu_s2_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b1;
      hcnt_q   <= '0;
      ref_q    <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      an_q     <= 4'hF;
      dp_q     <= 1'b1;
      // NOTE: the history is a tiny register file, not a RAM, so it is reset like any other flop.
      for (int k = 0; k < DIGITS; k++) hist_q[k] <= '0;
`ifdef SEG_HISTORY_FREEZE_EN
      frz_s1_q <= 1'b0;
      frz_s2_q <= 1'b0;
`endif
    end else begin
      cpu_s1_q <= cpuOut;
      cpu_s2_q <= cpu_s1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      if (commit) begin
        for (int k = DIGITS - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
        hist_q[0] <= cand_d;
        if (hcnt_q != FULL) hcnt_q <= hcnt_q + 3'd1;
      end
      if (ref_q == REF_LAST) begin
        ref_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      an_q  <= lit ? ~(4'b0001 << idx_q) : 4'hF;
      seg_q <= hex7(hist_q[idx_q]);
`ifdef SEG_HISTORY_FREEZE_EN
      frz_s1_q <= freeze;
      frz_s2_q <= frz_s1_q;
      dp_q     <= ~(lit && (idx_q == 2'd0) && frz_s2_q);
`else
      dp_q     <= 1'b1;
`endif
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign histCount = hcnt_q;

endmodule

// File: tb/tb_seg_display_history.sv
// Self-checking bench for seg_display_history: vector table, corner sequences and random stimulus
// against a run-length history model.
module tb_seg_display_history;

  localparam int RD = 4;
  localparam int SC = 3;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       freeze = 1'b0;
  logic [3:0] cpuOut = 4'h0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [2:0] histCount;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [3:0] d1, d2, run_val;
  logic       f1, f2, fired;
  int         run_len;
  int         cyc;
  logic [3:0] m_hist [$];

  always #5 clk = ~clk;

  seg_display_history #(.REFRESH_DIV(RD), .STABLE_CYCLES(SC), .DIGITS(4)) dut (
    .boardCLK (clk),
    .reset    (reset),
`ifdef SEG_HISTORY_FREEZE_EN
    .freeze   (freeze),
`endif
    .cpuOut   (cpuOut),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .histCount(histCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    d1 = '0; d2 = '0; f1 = 1'b0; f2 = 1'b0;
    run_val = '0; run_len = 1; fired = 1'b0;
    cyc = 0;
    m_hist.delete();
  endtask

  // One clock edge: predict outputs from pre-edge model state, advance model, compare.
  task automatic step();
    int idx;
    logic lit, frz, e_dp;
    logic [3:0] e_an, samp, shown;
    logic [6:0] e_seg;
    idx   = (cyc / RD) % 4;
    lit   = idx < m_hist.size();
    e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
    shown = lit ? m_hist[idx] : 4'h0;
    e_seg = SEG_TBL[shown];
`ifdef SEG_HISTORY_FREEZE_EN
    e_dp  = !(lit && idx == 0 && f2);
`else
    e_dp  = 1'b1;
`endif
    samp = d2; frz = f2;
    d2 = d1; d1 = cpuOut;
    f2 = f1; f1 = freeze;
    if (samp == run_val) run_len++;
    else begin run_val = samp; run_len = 1; fired = 1'b0; end
    if (!fired && run_len >= SC && !frz) begin
      fired = 1'b1;
      if (m_hist.size() == 0 || run_val != m_hist[0]) begin
        m_hist.push_front(run_val);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
      end
    end
    cyc++;
    @(posedge clk); #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("histCount", 32'(histCount), 32'(m_hist.size()));
  endtask

  // Assert reset away from the edge; display must blank before the next edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_histCount", 32'(histCount), 32'h0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_an", 32'(an), 32'hF);
    check("rst_hold_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
  endtask

  // Scan one full refresh round and compare each lit digit against the expected history.
  task automatic read_digits(input int exp_cnt, input logic [0:3][3:0] exp);
    logic [6:0] got [4];
    logic       seen [4];
    for (int i = 0; i < 4; i++) begin got[i] = 'x; seen[i] = 1'b0; end
    for (int c = 0; c < 4 * RD + 2; c++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (an == ~(4'b0001 << i)) begin got[i] = seg; seen[i] = 1'b1; end
    end
    check("tbl_histCount", 32'(histCount), 32'(exp_cnt));
    for (int i = 0; i < 4; i++) begin
      if (i < exp_cnt) begin
        check("tbl_digit_lit", 32'(seen[i]), 32'h1);
        check("tbl_digit_seg", 32'(got[i]), 32'(SEG_TBL[exp[i]]));
      end else begin
        check("tbl_digit_blank", 32'(seen[i]), 32'h0);
      end
    end
  endtask

  typedef struct {
    logic [3:0]       val;
    int               hold;
    logic             chk;
    int               exp_cnt;
    logic [0:3][3:0]  exp;   // exp[0] is the newest entry
  } vec_t;

  vec_t vecs [12];

  initial begin
    int found, saw_dp0, v, h;
    vecs = '{
      '{4'h3, 20, 1'b1, 2, 16'h3000},
      '{4'h7, 20, 1'b1, 3, 16'h7300},
      '{4'h9, 20, 1'b1, 4, 16'h9730},
      '{4'h2, 20, 1'b1, 4, 16'h2973},
      '{4'h5, 20, 1'b1, 4, 16'h5297},
      '{4'h6, 20, 1'b1, 4, 16'h6529},
      '{4'h4,  2, 1'b0, 4, 16'h6529},
      '{4'h6, 20, 1'b1, 4, 16'h6529},
      '{4'h1, 20, 1'b1, 4, 16'h1652},
      '{4'h1, 20, 1'b1, 4, 16'h1652},
      '{4'h6, 20, 1'b1, 4, 16'h6165},
      '{4'h1, 20, 1'b1, 4, 16'h1616}};
    model_reset();

    // Reset with cpuOut=0; 0 is committed shortly after release
    @(posedge clk); #1;
    cpuOut = 4'h0;
    do_reset();
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      step();
      if (histCount == 3'd1) found = 1;
    end
    check("t1_first_commit", 32'(found), 32'h1);
    read_digits(1, 16'h0000);

    // Table: saturation, glitch rejection, repeated values
    for (int r = 0; r < 12; r++) begin
      cpuOut = vecs[r].val;
      repeat (vecs[r].hold) step();
      if (vecs[r].chk) read_digits(vecs[r].exp_cnt, vecs[r].exp);
    end

    // Asynchronous reset mid-scan with three entries
    do_reset();
    cpuOut = 4'h8; repeat (20) step();
    cpuOut = 4'h3; repeat (20) step();
    check("t5_pre_count", 32'(histCount), 32'h3);
    repeat (5) step();
    do_reset();

`ifdef SEG_HISTORY_FREEZE_EN
    cpuOut = 4'h0;
    repeat (10) step();
    freeze = 1'b1;
    repeat (4) step();
    cpuOut = 4'hA;
    saw_dp0 = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (dp == 1'b0 && an == 4'b1110) saw_dp0 = 1;
    end
    check("frz_no_commit", 32'(histCount), 32'h1);
    check("frz_dp_low", 32'(saw_dp0), 32'h1);
    freeze = 1'b0;
    found = 0;
    for (int c = 1; c <= 6 && found == 0; c++) begin
      step();
      if (histCount == 3'd2) found = c;
    end
    check("frz_release_commit", 32'(found > 0 && found <= 3), 32'h1);
`endif

    // Random runs of varied length, including sub-threshold glitches
    for (int r = 0; r < 120; r++) begin
      v = $urandom_range(15);
      h = $urandom_range(6, 1);
      cpuOut = 4'(v);
`ifdef SEG_HISTORY_FREEZE_EN
      if ($urandom_range(7) == 0) freeze = ~freeze;
`endif
      repeat (h) step();
    end
    freeze = 1'b0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
